// File: rtl/instr_enc_pkg.sv
// instr_enc_pkg: shared definitions for the instruction encoder.
//   - op_e         : abstract micro-op codes accepted on in_op (10..15 illegal)
//   - OPC_* / FN_* : MIPS opcode and funct fields, same values as the decoder
//   - NOP_WORD     : encoding of the no-op word
//   - ENC_BASE_ADDR: default byte address of the first emitted word
// Optional feature macro used by the encoder: ENC_DELAY_SLOT_EN.
package instr_enc_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_ORI = 4'd2,
    OP_LW  = 4'd3,
    OP_SW  = 4'd4,
    OP_BEQ = 4'd5,
    OP_LUI = 4'd6,
    OP_JAL = 4'd7,
    OP_JR  = 4'd8,
    OP_NOP = 4'd9
  } op_e;

  localparam logic [3:0]  OP_LAST = 4'd9;

  localparam logic [5:0]  OPC_RTYPE = 6'b000000;
  localparam logic [5:0]  OPC_ORI   = 6'b001101;
  localparam logic [5:0]  OPC_LW    = 6'b100011;
  localparam logic [5:0]  OPC_SW    = 6'b101011;
  localparam logic [5:0]  OPC_BEQ   = 6'b000100;
  localparam logic [5:0]  OPC_LUI   = 6'b001111;
  localparam logic [5:0]  OPC_JAL   = 6'b000011;

  localparam logic [5:0]  FN_ADD = 6'b100000;
  localparam logic [5:0]  FN_SUB = 6'b100010;
  localparam logic [5:0]  FN_JR  = 6'b001000;

  localparam logic [31:0] NOP_WORD      = 32'h0000_0000;
  localparam logic [31:0] ENC_BASE_ADDR = 32'h0000_3000;

  // Ops that are followed by a delay-slot NOP when that feature is built in.
  function automatic logic is_branch(input logic [3:0] op);
    return (op == OP_BEQ) || (op == OP_JAL) || (op == OP_JR);
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// enc_fifo: DEPTH-entry FIFO of {addr,instr} words for the instruction encoder.
//   clk, reset (async, active high), clear (sync flush, priority over push/pop)
//   push/wdata   : write one entry
//   push2/wdata2 : with push, also write a second entry behind the first
//                  (used by the ENC_DELAY_SLOT_EN build for the delay-slot NOP)
//   pop          : remove head; ignored when empty
//   rdata        : head entry, or the last popped entry while empty
//   count        : number of stored entries
// The caller guarantees push/push2 only when enough entries are free.
module enc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic          push2,
  input  logic [W-1:0]  wdata,
  input  logic [W-1:0]  wdata2,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [W-1:0]  last;
  logic          do_pop;
  logic          do_push2;
  logic [1:0]    n_wr;

  assign do_pop   = pop && (cnt != '0);
  assign do_push2 = push && push2;
  assign n_wr     = {1'b0, push} + {1'b0, do_push2};

  always_ff @(posedge clk) begin
    if (!clear) begin
      if (push)     mem[wr_ptr] <= wdata;
      if (do_push2) mem[wr_ptr + AW'(1)] <= wdata2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      last   <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(n_wr);
      cnt    <= cnt + CW'(n_wr) - CW'(do_pop);
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last   <= mem[rd_ptr];
      end
    end
  end

  // Holding the last popped entry keeps the output stable while empty.
  assign rdata = (cnt != '0) ? mem[rd_ptr] : last;
  assign count = cnt;

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: turns abstract micro-op requests into 32-bit MIPS words,
// tags each with its byte address and buffers them in an output FIFO.
//   clk, reset (async, active high), clear (sync flush, err_cnt kept)
//   in_valid/in_ready, in_op, in_rs, in_rt, in_rd, in_imm : request side
//   out_valid/out_ready, out_instr, out_addr               : word side
//   err     : one-cycle pulse after an illegal op is consumed
//   err_cnt : saturating count of illegal ops
// Macro ENC_DELAY_SLOT_EN: when defined, BEQ/JAL/JR are followed by an
// automatically inserted NOP word at the next address.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = ENC_BASE_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [25:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [7:0]  err_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  op_e           op;
  logic [31:0]   word;
  logic [31:0]   next_addr;
  logic [31:0]   addr_step;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic          legal;
  logic          accept;
  logic          push;
  logic          push2;
  logic [63:0]   wdata2;
  logic [63:0]   rdata;

  assign op    = op_e'(in_op);
  assign legal = (in_op <= OP_LAST);
  assign free  = CW'(DEPTH) - count;

`ifdef ENC_DELAY_SLOT_EN
  assign in_ready  = is_branch(in_op) ? (free >= CW'(2)) : (free != '0);
  assign push2     = push && is_branch(in_op);
  assign wdata2    = {next_addr + 32'd4, NOP_WORD};
  assign addr_step = push2 ? 32'd8 : 32'd4;
`else
  assign in_ready  = (free != '0);
  assign push2     = 1'b0;
  assign wdata2    = '0;
  assign addr_step = 32'd4;
`endif

  // A request seen during clear is dropped, including illegal ones.
  assign accept = in_valid && in_ready && !clear;
  assign push   = accept && legal;

  always_comb begin
    word = NOP_WORD;
    case (op)
      OP_ADD:  word = {OPC_RTYPE, in_rs, in_rt, in_rd, 5'b0, FN_ADD};
      OP_SUB:  word = {OPC_RTYPE, in_rs, in_rt, in_rd, 5'b0, FN_SUB};
      OP_ORI:  word = {OPC_ORI, in_rs, in_rt, in_imm[15:0]};
      OP_LW:   word = {OPC_LW, in_rs, in_rt, in_imm[15:0]};
      OP_SW:   word = {OPC_SW, in_rs, in_rt, in_imm[15:0]};
      OP_BEQ:  word = {OPC_BEQ, in_rs, in_rt, in_imm[15:0]};
      OP_LUI:  word = {OPC_LUI, 5'b0, in_rt, in_imm[15:0]};
      OP_JAL:  word = {OPC_JAL, in_imm};
      OP_JR:   word = {OPC_RTYPE, in_rs, 15'b0, FN_JR};
      default: word = NOP_WORD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_addr <= BASE_ADDR;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else if (clear) begin
      next_addr <= BASE_ADDR;
      err       <= 1'b0;
    end else begin
      err <= accept && !legal;
      if (accept && !legal && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'd1;
      if (push)
        next_addr <= next_addr + addr_step;
    end
  end

  enc_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .push   (push),
    .push2  (push2),
    .wdata  ({next_addr, word}),
    .wdata2 (wdata2),
    .pop    (out_ready),
    .rdata  (rdata),
    .count  (count)
  );

  assign out_valid = (count != '0);
  assign out_addr  = rdata[63:32];
  assign out_instr = rdata[31:0];

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  import instr_enc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [25:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;
  logic [7:0]  err_cnt;

  int n_tot = 0;
  int n_bad = 0;

  instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0000_3000)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [25:0] imm);
    in_valid = 1'b1;
    in_op    = op;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
    in_imm   = imm;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

`ifdef ENC_DELAY_SLOT_EN
  localparam int NJ = 4;
  logic [31:0] j_instr [NJ] = '{32'h0C00_0C03, 32'h0, 32'h03E0_0008, 32'h0};
  logic [31:0] j_addr  [NJ] = '{32'h3000, 32'h3004, 32'h3008, 32'h300C};
`else
  localparam int NJ = 2;
  logic [31:0] j_instr [NJ] = '{32'h0C00_0C03, 32'h03E0_0008};
  logic [31:0] j_addr  [NJ] = '{32'h3000, 32'h3004};
`endif

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    cyc();

    // basic encode, one-cycle latency, push+pop overlap, hold when empty
    out_ready = 1'b1;
    push(OP_ADD, 5'd1, 5'd2, 5'd3, 26'h0);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_instr", out_instr, 32'h0022_1820);
    chk("add_addr", out_addr, 32'h0000_3000);
    push(OP_ORI, 5'd0, 5'd5, 5'd9, 26'h3AB_1234);
    chk("ori_instr", out_instr, 32'h3405_1234);
    chk("ori_addr", out_addr, 32'h0000_3004);
    cyc();
    chk("empty_valid", 32'(out_valid), 32'd0);
    chk("hold_instr", out_instr, 32'h3405_1234);
    chk("hold_addr", out_addr, 32'h0000_3004);

    // fill to full, push+pop while full, drain in order
    out_ready = 1'b0;
    do_clear();
    for (int i = 0; i < 4; i++) begin
      push(OP_LUI, 5'd7, 5'd1, 5'd7, 26'h0FF_FFFF);
      chk($sformatf("lui_ready%0d", i), 32'(in_ready), (i < 3) ? 32'd1 : 32'd0);
    end
    chk("full_head_instr", out_instr, 32'h3C01_FFFF);
    chk("full_head_addr", out_addr, 32'h0000_3000);
    in_valid = 1'b1; in_op = OP_ADD; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("full_pop_only_ready", 32'(in_ready), 32'd1);
    for (int k = 1; k < 4; k++) begin
      chk($sformatf("drain_instr%0d", k), out_instr, 32'h3C01_FFFF);
      chk($sformatf("drain_addr%0d", k), out_addr, 32'h0000_3000 + 32'(4 * k));
      cyc();
    end
    chk("drained_valid", 32'(out_valid), 32'd0);
    push(OP_NOP, 5'd7, 5'd7, 5'd7, 26'h3FF_FFFF);
    chk("nop_instr", out_instr, 32'h0);
    chk("nop_addr_after_reject", out_addr, 32'h0000_3010);
    cyc();

    // simultaneous push/pop at count=2
    out_ready = 1'b0;
    push(OP_SW, 5'd3, 5'd4, 5'd0, 26'h0010);
    push(OP_LW, 5'd3, 5'd4, 5'd0, 26'h0008);
    chk("sw_head", out_instr, 32'hAC64_0010);
    in_valid = 1'b1; in_op = OP_SUB; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("pp_head_instr", out_instr, 32'h8C64_0008);
    chk("pp_head_addr", out_addr, 32'h0000_3018);
    push(OP_ORI, 5'd0, 5'd6, 5'd0, 26'h00AA);
    chk("pp_count3_ready", 32'(in_ready), 32'd1);
    push(OP_ORI, 5'd1, 5'd6, 5'd0, 26'h00BB);
    chk("pp_count4_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    chk("ord0", out_addr, 32'h0000_3018);
    cyc();
    chk("ord1_instr", out_instr, 32'h0022_1822);
    chk("ord1_addr", out_addr, 32'h0000_301C);
    out_ready = 1'b0;

    // clear with 3 words buffered and a request presented alongside
    clear = 1'b1; in_valid = 1'b1; in_op = OP_ADD; out_ready = 1'b1;
    cyc();
    clear = 1'b0; in_valid = 1'b0;
    chk("clear_valid", 32'(out_valid), 32'd0);
    push(OP_ADD, 5'd1, 5'd2, 5'd3, 26'h0);
    chk("post_clear_addr", out_addr, 32'h0000_3000);
    cyc();

    // illegal ops
    do_clear();
    push(4'd12, 5'd1, 5'd2, 5'd3, 26'h0);
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_cnt", 32'(err_cnt), 32'd1);
    chk("ill_no_word", 32'(out_valid), 32'd0);
    cyc();
    chk("ill_err_pulse", 32'(err), 32'd0);
    push(OP_ADD, 5'd1, 5'd2, 5'd3, 26'h0);
    chk("ill_addr_kept", out_addr, 32'h0000_3000);
    cyc();
    in_valid = 1'b1; in_op = 4'd15;
    repeat (300) cyc();
    in_valid = 1'b0;
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);
    do_clear();
    chk("err_cnt_kept", 32'(err_cnt), 32'd255);

    // JAL / JR (plus delay-slot NOPs when built in)
    out_ready = 1'b0;
    push(OP_JAL, 5'd9, 5'd9, 5'd9, 26'h000_0C03);
    push(OP_JR, 5'd31, 5'd9, 5'd9, 26'h3FF_FFFF);
    out_ready = 1'b1;
    for (int k = 0; k < NJ; k++) begin
      chk($sformatf("j_instr%0d", k), out_instr, j_instr[k]);
      chk($sformatf("j_addr%0d", k), out_addr, j_addr[k]);
      cyc();
    end
    chk("j_empty", 32'(out_valid), 32'd0);

    // asynchronous reset mid-burst
    out_ready = 1'b0;
    push(OP_ADD, 5'd1, 5'd2, 5'd3, 26'h0);
    push(OP_SUB, 5'd1, 5'd2, 5'd3, 26'h0);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_instr", out_instr, 32'd0);
    chk("arst_addr", out_addr, 32'd0);
    chk("arst_err_cnt", 32'(err_cnt), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    push(OP_ADD, 5'd1, 5'd2, 5'd3, 26'h0);
    chk("arst_next_addr", out_addr, 32'h0000_3000);
    cyc();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the instruction decoder. Accepts abstract micro-op requests (op code, register fields, immediate) on a valid/ready input.
- Encodes each request into a 32-bit MIPS word and tags it with its byte address.
- Buffers the words in a small FIFO and presents them on a valid/ready output.
- Feeds the instruction-memory loader and bench program generators for the P4 CPU.

Parameters:
- DEPTH, 4, output FIFO entries (power of two, ≥2).
- BASE_ADDR, 32'h0000_3000, byte address of the first emitted word.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous flush: empties the FIFO, address back to BASE_ADDR, err_cnt kept
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid&in_ready
- in_op  in  4  ADD=0 SUB=1 ORI=2 LW=3 SW=4 BEQ=5 LUI=6 JAL=7 JR=8 NOP=9; 10..15 illegal
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_imm  in  26  [15:0] for I-type, [25:0] for JAL
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer takes head when out_valid&out_ready
- out_instr  out  32  encoded word
- out_addr  out  32  byte address of out_instr
- err  out  1  one-cycle pulse, illegal op accepted
- err_cnt  out  8  saturating illegal-op count

Behaviour:
- Reset (async): FIFO empty, out_valid=0, out_instr=0, out_addr=0, err=0, err_cnt=0, next address=BASE_ADDR, in_ready=1.
- in_ready = !full. It is computed from the registered count only; there is no same-cycle pass-through when full.
- Encoding, combinational on the inputs, written into the FIFO on accept:
  - ADD: {000000,rs,rt,rd,00000,100000}
  - SUB: as ADD with funct 100010
  - ORI: {001101,rs,rt,imm[15:0]}
  - LW: {100011,rs,rt,imm[15:0]}
  - SW: {101011,rs,rt,imm[15:0]}
  - BEQ: {000100,rs,rt,imm[15:0]}
  - LUI: {001111,00000,rt,imm[15:0]}
  - JAL: {000011,imm[25:0]}
  - JR: {000000,rs,15'b0,001000}
  - NOP: 32'h0000_0000
- Fields not used by an op are ignored and forced to zero in the word.
- Each enqueued word is tagged with the current address. The address then advances by 4 and wraps modulo 2^32.
- Latency: a request accepted in cycle N appears at the output in cycle N+1 when the FIFO was empty. No combinational path from input to output.
- Illegal op while in_ready=1:
  - The request is consumed: no FIFO write, address unchanged.
  - err=1 in the next cycle.
  - err_cnt increments and saturates at 255.
- Simultaneous push and pop: allowed whenever in_ready=1. The count is unchanged and the order is strictly FIFO.
- Pop when empty: ignored. out_instr and out_addr hold their last values while out_valid=0.
- clear has priority over push and pop in the same cycle. A request presented during clear is dropped.
- Reset mid-stream discards all buffered words immediately.

Optional Feature:
- Macro ENC_DELAY_SLOT_EN.
- Defined:
  - After every BEQ, JAL or JR the block auto-enqueues a NOP word. The NOP gets the next address, so the branch consumes 8 bytes.
  - For these three ops, in_ready additionally requires ≥2 free entries.
  - The branch and its NOP are written in the same cycle.
- Undefined: no NOP insertion, and in_ready=!full for all ops.

Decomposition:
- Package instr_enc_pkg holds:
  - the op enum constants
  - opcode/funct constants, shared with the decoder's opcode/funct definitions
  - NOP word
  - BASE_ADDR default
- Sub-module enc_fifo is natural: parameterised DEPTH×64-bit storage {addr,instr} with count, push2 port used under ENC_DELAY_SLOT_EN, and clear. Encoding logic stays in the top level.

Test Plan:
- Reset then ADD rs=1 rt=2 rd=3, out_ready=1 → next cycle out_instr=32'h0022_1820, out_addr=32'h0000_3000. Then ORI rs=0 rt=5 imm=16'h1234 → 32'h3405_1234 at 32'h0000_3004.
- out_ready=0, push 4 LUI (rt=1, imm=16'hFFFF) → in_ready=0 after the 4th. Then drain → four 32'h3C01_FFFF at addresses 3000, 3004, 3008, 300C in order.
- in_op=12 → no output word, err pulse 1 cycle, err_cnt=1. Next valid op still gets address 32'h0000_3000. 300 illegal ops → err_cnt=255.
- JAL imm=26'h0000C03, then JR rs=31 → 32'h0C00_0C03 and 32'h03E0_0008. With ENC_DELAY_SLOT_EN each is followed by 32'h0, at addresses 3000/3004/3008/300C.
- Full FIFO with push and pop asserted together → only the pop occurs, because in_ready=0. With count=2, simultaneous push/pop → count stays 2.
- Assert clear with 3 buffered words → out_valid=0 next cycle, next push tagged 32'h0000_3000. Assert async reset mid-burst → outputs zero without a clock edge.
